// File: rtl/mii_sched_pkg.sv
// Shared types and defaults for the MII TX frame scheduler.
package mii_sched_pkg;
  typedef enum logic [1:0] {IDLE, SEND, IPG} state_t;

  localparam int BEAT_BYTES    = 8;
  localparam int DEF_IPG_BYTES = 12;
  localparam int DEF_MIN_FRAME = 64;
  localparam int DEF_MAX_FRAME = 1526;
  localparam int IPG_CNT_W     = 8;
endpackage

// File: rtl/mii_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after pointer, wrapping.
module rr_arbiter #(
  parameter int  NUM_REQ = 2,
  localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   pointer,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   idx
);
  logic found;
  int   c;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(pointer) + i) % NUM_REQ;
      if (enable && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end
endmodule

// File: rtl/mii_tx_scheduler.sv
// Round-robin frame scheduler in front of the 64-bit MII TX generator.
// Define MII_TX_SCHED_DIC_EN to enable deficit idle count on the inter-packet gap.
module mii_tx_scheduler
  import mii_sched_pkg::*;
#(
  parameter int  NUM_REQ   = 2,
  parameter int  LEN_W     = 16,
  parameter int  MIN_FRAME = DEF_MIN_FRAME,
  parameter int  MAX_FRAME = DEF_MAX_FRAME,
  parameter int  IPG_BYTES = DEF_IPG_BYTES,
  localparam int SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*LEN_W-1:0] i_len,
  input  logic                     i_pause,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [SEL_W-1:0]         o_sel,
  output logic [LEN_W-1:0]         o_len,
  output logic                     o_valid,
  output logic                     o_mac_done,
  output logic                     o_busy
);
  localparam int BEAT_W = LEN_W - 2;

  state_t                        state;
  logic [SEL_W-1:0]              ptr;
  logic [BEAT_W-1:0]             beat, beats;
  logic [IPG_CNT_W-1:0]          ipg_cnt;
  logic [NUM_REQ-1:0][LEN_W-1:0] len_arr;

  logic                 last_beat, arb_pt, arb_win;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [SEL_W-1:0]     arb_idx;
  logic [LEN_W-1:0]     win_len;
  logic [BEAT_W-1:0]    win_beats;
  logic [2:0]           tail;
  int                   r, kc;
  logic [IPG_CNT_W-1:0] gap_k;
`ifdef MII_TX_SCHED_DIC_EN
  logic [1:0] dic, dic_nxt;
  int         kd, s, dt;
`endif

  assign len_arr   = i_len;
  assign last_beat = (state == SEND) && (beat == beats);
  assign arb_pt    = (state == IDLE) || (last_beat && gap_k == '0) ||
                     (state == IPG && ipg_cnt == IPG_CNT_W'(1));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (i_req),
    .pointer (ptr),
    .enable  (arb_pt && !i_pause),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );
  assign arb_win = |arb_grant;

  // Clamp first so the beat count always reflects the length actually sent.
  always_comb begin
    win_len = len_arr[arb_idx];
    if (win_len < LEN_W'(MIN_FRAME))      win_len = LEN_W'(MIN_FRAME);
    else if (win_len > LEN_W'(MAX_FRAME)) win_len = LEN_W'(MAX_FRAME);
    win_beats = BEAT_W'((int'(win_len) + BEAT_BYTES - 1) / BEAT_BYTES);
  end

  // Unused bytes of the last beat count toward the gap; the rest is whole idle beats.
  always_comb begin
    tail = 3'(3'd0 - o_len[2:0]);
    r    = (IPG_BYTES > int'(tail)) ? IPG_BYTES - int'(tail) : 0;
    kc   = (r + BEAT_BYTES - 1) / BEAT_BYTES;
`ifdef MII_TX_SCHED_DIC_EN
    kd      = r / BEAT_BYTES;
    s       = r - BEAT_BYTES * kd;
    dt      = 0;
    gap_k   = IPG_CNT_W'(kc);
    dic_nxt = dic;
    if (int'(dic) + s <= 3) begin
      gap_k   = IPG_CNT_W'(kd);
      dic_nxt = 2'(int'(dic) + s);
    end else begin
      dt      = int'(dic) - (BEAT_BYTES * kc - r);
      dic_nxt = (dt < 0) ? 2'd0 : 2'(dt);
    end
`else
    gap_k = IPG_CNT_W'(kc);
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= SEL_W'(NUM_REQ - 1);
      beat       <= '0;
      beats      <= '0;
      ipg_cnt    <= '0;
      o_grant    <= '0;
      o_sel      <= '0;
      o_len      <= '0;
      o_valid    <= 1'b0;
      o_mac_done <= 1'b0;
      o_busy     <= 1'b0;
`ifdef MII_TX_SCHED_DIC_EN
      dic        <= 2'd0;
`endif
    end else begin
      o_grant <= '0;
`ifdef MII_TX_SCHED_DIC_EN
      if (last_beat) dic <= dic_nxt;
`endif
      if (arb_win) begin
        o_grant    <= arb_grant;
        o_sel      <= arb_idx;
        o_len      <= win_len;
        ptr        <= arb_idx;
        state      <= SEND;
        beat       <= BEAT_W'(1);
        beats      <= win_beats;
        o_valid    <= 1'b1;
        o_mac_done <= (win_beats == BEAT_W'(1));
        o_busy     <= 1'b1;
      end else begin
        case (state)
          SEND: begin
            if (beat == beats) begin
              o_valid    <= 1'b0;
              o_mac_done <= 1'b0;
              ipg_cnt    <= gap_k;
              state      <= (gap_k != '0) ? IPG : IDLE;
              o_busy     <= (gap_k != '0);
            end else begin
              beat       <= beat + BEAT_W'(1);
              o_mac_done <= (beat + BEAT_W'(1) == beats);
            end
          end
          IPG: begin
            if (ipg_cnt == IPG_CNT_W'(1)) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
            ipg_cnt <= ipg_cnt - IPG_CNT_W'(1);
          end
          default: begin
            o_valid    <= 1'b0;
            o_mac_done <= 1'b0;
            o_busy     <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Directed self-checking bench for mii_tx_scheduler (2 requesters, 16-bit lengths).
module tb_mii_tx_scheduler;
`ifdef MII_TX_SCHED_DIC_EN
  localparam int G70A = 1, G1526 = 1;
`else
  localparam int G70A = 2, G1526 = 2;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [31:0] i_len;
  logic        i_pause;
  logic [1:0]  o_grant;
  logic        o_sel;
  logic [15:0] o_len;
  logic        o_valid, o_mac_done, o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  mii_tx_scheduler #(.NUM_REQ(2), .LEN_W(16)) dut (
    .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_len(i_len), .i_pause(i_pause),
    .o_grant(o_grant), .o_sel(o_sel), .o_len(o_len), .o_valid(o_valid),
    .o_mac_done(o_mac_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_grant != 2'b00) begin ok = 1'b1; break; end
    end
  endtask

  // Starts on beat 1; returns valid beats, beat index of o_mac_done, and idle-busy cycles.
  task automatic measure_frame(output int nb, output int done_at, output int gap);
    nb = 0; done_at = 0; gap = 0;
    while (o_valid && done_at == 0 && nb < 400) begin
      nb++;
      if (o_mac_done) done_at = nb;
      tick();
    end
    while (o_busy && !o_valid && gap < 40) begin
      gap++;
      tick();
    end
  endtask

  task automatic test_reset();
    int nb, da, gp;
    i_rst = 1'b1; i_req = 2'b01; i_len = {16'd64, 16'd64}; i_pause = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({o_grant, o_sel, o_len, o_valid, o_mac_done, o_busy} !== 22'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {o_grant, o_sel, o_len, o_valid, o_mac_done, o_busy}); end
    i_rst = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant: got %b want 01", o_grant); end
    n_cmp++; if (o_sel !== 1'b0) begin n_bad++; $display("FAIL reset_first_sel: got %0d want 0", o_sel); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_valid: got %b want 1", o_valid); end
    i_req = 2'b00;
    tick();
    n_cmp++; if (o_grant !== 2'b00) begin n_bad++; $display("FAIL grant_pulse_width: got %b want 00", o_grant); end
    measure_frame(nb, da, gp);
  endtask

  task automatic test_single();
    int nb, da, gp;
    bit ok;
    i_len[15:0] = 16'd64; i_req = 2'b01;
    wait_grant(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single64_grant: got timeout want grant"); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (nb !== 8) begin n_bad++; $display("FAIL single64_beats: got %0d want 8", nb); end
    n_cmp++; if (da !== 8) begin n_bad++; $display("FAIL single64_done_beat: got %0d want 8", da); end
    n_cmp++; if (gp !== 2) begin n_bad++; $display("FAIL single64_gap: got %0d want 2", gp); end
    i_len[15:0] = 16'd65; i_req = 2'b01;
    wait_grant(ok);
    n_cmp++; if (o_len !== 16'd65) begin n_bad++; $display("FAIL single65_len: got %0d want 65", o_len); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (da !== 9) begin n_bad++; $display("FAIL single65_done_beat: got %0d want 9", da); end
    n_cmp++; if (gp !== 1) begin n_bad++; $display("FAIL single65_gap: got %0d want 1", gp); end
  endtask

  task automatic test_round_robin();
    int nb, da, gp;
    bit ok;
    logic [1:0] exp_g [4];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    i_len = {16'd64, 16'd64}; i_req = 2'b11;
    wait_grant(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_first_grant: got timeout want grant"); end
    for (int f = 0; f < 4; f++) begin
      n_cmp++; if (o_grant !== exp_g[f]) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", f, o_grant, exp_g[f]); end
      if (f == 3) i_req = 2'b00;
      measure_frame(nb, da, gp);
      n_cmp++; if (gp !== 2) begin n_bad++; $display("FAIL rr_gap%0d: got %0d want 2", f, gp); end
      if (f < 3) begin
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL rr_next_start%0d: got %b want 1", f, o_valid); end
      end
    end
  endtask

  task automatic test_dic();
    int nb, da, gp;
    bit ok;
    i_len[15:0] = 16'd70; i_req = 2'b01;
    wait_grant(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dic_grant1: got timeout want grant"); end
    measure_frame(nb, da, gp);
    n_cmp++; if (gp !== G70A) begin n_bad++; $display("FAIL dic_gap1: got %0d want %0d", gp, G70A); end
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL dic_grant2: got %b want 01", o_grant); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (nb !== 9) begin n_bad++; $display("FAIL dic_beats2: got %0d want 9", nb); end
    n_cmp++; if (gp !== 2) begin n_bad++; $display("FAIL dic_gap2: got %0d want 2", gp); end
  endtask

  task automatic test_pause();
    int nb, da, gp, ng;
    bit ok;
    i_len[15:0] = 16'd64; i_req = 2'b01;
    wait_grant(ok);
    repeat (3) tick();
    i_pause = 1'b1;
    measure_frame(nb, da, gp);
    n_cmp++; if (da !== 5) begin n_bad++; $display("FAIL pause_frame_completes: got %0d want 5", da); end
    n_cmp++; if (gp !== 2) begin n_bad++; $display("FAIL pause_gap: got %0d want 2", gp); end
    ng = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_grant != 2'b00 || o_valid) ng++;
      tick();
    end
    n_cmp++; if (ng !== 0) begin n_bad++; $display("FAIL pause_blocks_grant: got %0d want 0", ng); end
    i_pause = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL pause_release_grant: got %b want 01", o_grant); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
  endtask

  task automatic test_clamp();
    int nb, da, gp;
    bit ok;
    i_len[15:0] = 16'd10; i_req = 2'b01;
    wait_grant(ok);
    n_cmp++; if (o_len !== 16'd64) begin n_bad++; $display("FAIL clamp_min_len: got %0d want 64", o_len); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (da !== 8) begin n_bad++; $display("FAIL clamp_min_beats: got %0d want 8", da); end
    i_len[15:0] = 16'd2000; i_req = 2'b01;
    wait_grant(ok);
    n_cmp++; if (o_len !== 16'd1526) begin n_bad++; $display("FAIL clamp_max_len: got %0d want 1526", o_len); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (nb !== 191) begin n_bad++; $display("FAIL clamp_max_beats: got %0d want 191", nb); end
    n_cmp++; if (da !== 191) begin n_bad++; $display("FAIL clamp_max_done: got %0d want 191", da); end
    n_cmp++; if (gp !== G1526) begin n_bad++; $display("FAIL clamp_max_gap: got %0d want %0d", gp, G1526); end
  endtask

  task automatic test_reset_mid_frame();
    int nb, da, gp;
    bit ok;
    i_len[15:0] = 16'd64; i_req = 2'b01;
    wait_grant(ok);
    i_req = 2'b00;
    repeat (3) tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_beat4_valid: got %b want 1", o_valid); end
    i_rst = 1'b1; i_req = 2'b11; i_len[15:0] = 16'd70;
    tick();
    n_cmp++; if ({o_valid, o_mac_done, o_busy} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_abort: got %b want 000", {o_valid, o_mac_done, o_busy}); end
    tick();
    i_rst = 1'b0;
    tick();
    n_cmp++; if (o_grant !== 2'b01) begin n_bad++; $display("FAIL midrst_pointer: got %b want 01", o_grant); end
    i_req = 2'b00;
    measure_frame(nb, da, gp);
    n_cmp++; if (da !== 9) begin n_bad++; $display("FAIL midrst_beats: got %0d want 9", da); end
    n_cmp++; if (gp !== G70A) begin n_bad++; $display("FAIL midrst_dic_cleared: got %0d want %0d", gp, G70A); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dic();
    test_pause();
    test_clamp();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
